// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome encoding plus the branch resolution
// queue entry state and payload layout.
package mips_core_pkg;

   localparam int CORE_ADDR_WIDTH     = 32;
   localparam int CORE_G_HISTORY_BITS = 12;

   typedef enum logic {
      NOT_TAKEN = 1'b0,
      TAKEN     = 1'b1
   } BranchOutcome;

   typedef enum logic [1:0] {
      FREE     = 2'd0,
      PENDING  = 2'd1,
      RESOLVED = 2'd2
   } brq_state_e;

   typedef struct packed {
      logic [CORE_ADDR_WIDTH-1:0]     pc;
      logic [CORE_ADDR_WIDTH-1:0]     target;
      logic [CORE_G_HISTORY_BITS-1:0] ghistory;
      BranchOutcome                   prediction;
      BranchOutcome                   outcome;
   } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue.sv
// Branch resolution queue: in-order retirement of predicted branches,
// predictor feedback and a single redirect on the oldest misprediction.
// Payload fields follow the package widths, so ADDR_WIDTH and GH_BITS are
// expected to stay at their package defaults.
module branch_resolve_queue
   import mips_core_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = CORE_ADDR_WIDTH,
   parameter int GH_BITS    = CORE_G_HISTORY_BITS,
   parameter int TAG_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_alloc_valid,
   output logic                  o_alloc_ready,
   input  logic [ADDR_WIDTH-1:0] i_alloc_pc,
   input  logic [ADDR_WIDTH-1:0] i_alloc_target,
   input  BranchOutcome          i_alloc_prediction,
   input  logic [GH_BITS-1:0]    i_alloc_ghistory,
   output logic [TAG_W-1:0]      o_alloc_tag,
   input  logic                  i_res_valid,
   input  logic [TAG_W-1:0]      i_res_tag,
   input  BranchOutcome          i_res_outcome,
   output logic                  o_fb_valid,
   output logic [ADDR_WIDTH-1:0] o_fb_pc,
   output logic [GH_BITS-1:0]    o_fb_ghistory,
   output BranchOutcome          o_fb_prediction,
   output BranchOutcome          o_fb_outcome,
   output logic                  o_redirect_valid,
   output logic [ADDR_WIDTH-1:0] o_redirect_pc,
   output logic [31:0]           o_branch_count,
   output logic [31:0]           o_mispredict_count
);

   // Count needs one extra bit so that "full" (count == DEPTH) is representable.
   localparam int              CNT_W      = TAG_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   brq_state_e             state_q [DEPTH];
   brq_state_e             state_d [DEPTH];
   brq_entry_t             entry_q [DEPTH];
   brq_entry_t             entry_d [DEPTH];
   logic [TAG_W-1:0]       head_q, head_d;
   logic [TAG_W-1:0]       tail_q, tail_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   alloc_ready_q, alloc_ready_d;
   logic                   fb_valid_q, fb_valid_d;
   brq_entry_t             fb_q, fb_d;
   logic                   redirect_valid_q, redirect_valid_d;
   logic [ADDR_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
   logic [31:0]            branch_count_q, branch_count_d;
   logic [31:0]            mispredict_count_q, mispredict_count_d;

   brq_entry_t             head_entry;
   logic                   retire;
   logic                   mispredict;
   logic                   alloc_fire;

   // Next-state for the queue: resolve, retire, allocate, then flush on mispredict.
   always_comb begin
      // NOTE: every signal gets a default before any conditional update so no latch is inferred.
      state_d            = state_q;
      entry_d            = entry_q;
      head_d             = head_q;
      tail_d             = tail_q;
      fb_valid_d         = 1'b0;
      fb_d               = fb_q;
      redirect_valid_d   = 1'b0;
      redirect_pc_d      = redirect_pc_q;
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;

      head_entry = entry_q[head_q];
      retire     = (state_q[head_q] == RESOLVED);
      mispredict = retire && (head_entry.outcome != head_entry.prediction);
      // An allocation racing a mispredicting retire is on the wrong path.
      alloc_fire = i_alloc_valid && alloc_ready_q && !mispredict;

      if (i_res_valid && (state_q[i_res_tag] == PENDING)) begin
         state_d[i_res_tag]         = RESOLVED;
         entry_d[i_res_tag].outcome = i_res_outcome;
      end

      if (retire) begin
         state_d[head_q] = FREE;
         head_d          = head_q + TAG_W'(1);
         fb_valid_d      = 1'b1;
         fb_d            = head_entry;
         branch_count_d  = branch_count_q + 32'd1;
      end

      if (alloc_fire) begin
         state_d[tail_q]            = PENDING;
         entry_d[tail_q].pc         = i_alloc_pc;
         entry_d[tail_q].target     = i_alloc_target;
         entry_d[tail_q].ghistory   = i_alloc_ghistory;
         entry_d[tail_q].prediction = i_alloc_prediction;
         entry_d[tail_q].outcome    = i_alloc_prediction;
         tail_d                     = tail_q + TAG_W'(1);
      end

      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(retire);

      // Flush everything younger than the mispredicting head; this also
      // overrides any resolve landing on a flushed entry this cycle.
      if (mispredict) begin
         for (int i = 0; i < DEPTH; i++) state_d[i] = FREE;
         tail_d             = head_q + TAG_W'(1);
         count_d            = '0;
         redirect_valid_d   = 1'b1;
         redirect_pc_d      = (head_entry.outcome == TAKEN) ? head_entry.target
                                                            : head_entry.pc + ADDR_WIDTH'(8);
         mispredict_count_d = mispredict_count_q + 32'd1;
      end

      alloc_ready_d = (count_d < FULL_COUNT);
   end

   // Control state and output registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) state_q[i] <= FREE;
         head_q             <= '0;
         tail_q             <= '0;
         count_q            <= '0;
         alloc_ready_q      <= 1'b1;
         fb_valid_q         <= 1'b0;
         fb_q               <= '0;
         redirect_valid_q   <= 1'b0;
         redirect_pc_q      <= '0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         state_q            <= state_d;
         head_q             <= head_d;
         tail_q             <= tail_d;
         count_q            <= count_d;
         alloc_ready_q      <= alloc_ready_d;
         fb_valid_q         <= fb_valid_d;
         fb_q               <= fb_d;
         redirect_valid_q   <= redirect_valid_d;
         redirect_pc_q      <= redirect_pc_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   // Entry payload storage.
   always_ff @(posedge clk) begin
      // NOTE: payload is not reset; the per-entry state guards every read, so stale data is never used.
      entry_q <= entry_d;
   end

   assign o_alloc_ready      = alloc_ready_q;
   assign o_alloc_tag        = tail_q;
   assign o_fb_valid         = fb_valid_q;
   assign o_fb_pc            = fb_q.pc;
   assign o_fb_ghistory      = fb_q.ghistory;
   assign o_fb_prediction    = fb_q.prediction;
   assign o_fb_outcome       = fb_q.outcome;
   assign o_redirect_valid   = redirect_valid_q;
   assign o_redirect_pc      = redirect_pc_q;
   assign o_branch_count     = branch_count_q;
   assign o_mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: inputs change and outputs are
// sampled on the falling clock edge.
module tb_branch_resolve_queue;
   import mips_core_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int GH    = 12;
   localparam int TW    = 2;

   logic          clk;
   logic          rst;
   logic          i_alloc_valid;
   logic          o_alloc_ready;
   logic [AW-1:0] i_alloc_pc;
   logic [AW-1:0] i_alloc_target;
   BranchOutcome  i_alloc_prediction;
   logic [GH-1:0] i_alloc_ghistory;
   logic [TW-1:0] o_alloc_tag;
   logic          i_res_valid;
   logic [TW-1:0] i_res_tag;
   BranchOutcome  i_res_outcome;
   logic          o_fb_valid;
   logic [AW-1:0] o_fb_pc;
   logic [GH-1:0] o_fb_ghistory;
   BranchOutcome  o_fb_prediction;
   BranchOutcome  o_fb_outcome;
   logic          o_redirect_valid;
   logic [AW-1:0] o_redirect_pc;
   logic [31:0]   o_branch_count;
   logic [31:0]   o_mispredict_count;

   int vectors;
   int miscompares;

   branch_resolve_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .GH_BITS(GH), .TAG_W(TW)) dut (
      .clk                (clk),
      .rst                (rst),
      .i_alloc_valid      (i_alloc_valid),
      .o_alloc_ready      (o_alloc_ready),
      .i_alloc_pc         (i_alloc_pc),
      .i_alloc_target     (i_alloc_target),
      .i_alloc_prediction (i_alloc_prediction),
      .i_alloc_ghistory   (i_alloc_ghistory),
      .o_alloc_tag        (o_alloc_tag),
      .i_res_valid        (i_res_valid),
      .i_res_tag          (i_res_tag),
      .i_res_outcome      (i_res_outcome),
      .o_fb_valid         (o_fb_valid),
      .o_fb_pc            (o_fb_pc),
      .o_fb_ghistory      (o_fb_ghistory),
      .o_fb_prediction    (o_fb_prediction),
      .o_fb_outcome       (o_fb_outcome),
      .o_redirect_valid   (o_redirect_valid),
      .o_redirect_pc      (o_redirect_pc),
      .o_branch_count     (o_branch_count),
      .o_mispredict_count (o_mispredict_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      i_alloc_valid      = 1'b0;
      i_alloc_pc         = '0;
      i_alloc_target     = '0;
      i_alloc_prediction = NOT_TAKEN;
      i_alloc_ghistory   = '0;
      i_res_valid        = 1'b0;
      i_res_tag          = '0;
      i_res_outcome      = NOT_TAKEN;
   endtask

   // One rising edge passes; returns on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic alloc(input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                        input BranchOutcome pred, input logic [GH-1:0] gh);
      i_alloc_valid      = 1'b1;
      i_alloc_pc         = pc;
      i_alloc_target     = tgt;
      i_alloc_prediction = pred;
      i_alloc_ghistory   = gh;
   endtask

   task automatic resolve(input logic [TW-1:0] tag, input BranchOutcome outcome);
      i_res_valid   = 1'b1;
      i_res_tag     = tag;
      i_res_outcome = outcome;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (o_alloc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0b exp 1", o_alloc_ready); end
      vectors++; if (o_alloc_tag !== 2'd0) begin miscompares++; $display("FAIL reset_tag got %0d exp 0", o_alloc_tag); end
      vectors++; if (o_fb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fb_valid got %0b exp 0", o_fb_valid); end
      vectors++; if (o_fb_pc !== 32'h0) begin miscompares++; $display("FAIL reset_fb_pc got %h exp 0", o_fb_pc); end
      vectors++; if (o_redirect_valid !== 1'b0 || o_redirect_pc !== 32'h0) begin miscompares++; $display("FAIL reset_redirect got %0b/%h exp 0/0", o_redirect_valid, o_redirect_pc); end
      vectors++; if (o_branch_count !== 32'd0 || o_mispredict_count !== 32'd0) begin miscompares++; $display("FAIL reset_counts got %0d/%0d exp 0/0", o_branch_count, o_mispredict_count); end
   endtask

   task automatic test_correct_retire();
      do_reset();
      alloc(32'h100, 32'h200, NOT_TAKEN, 12'h0A5); step(); idle();
      vectors++; if (o_alloc_tag !== 2'd1) begin miscompares++; $display("FAIL single_tag got %0d exp 1", o_alloc_tag); end
      resolve(2'd0, NOT_TAKEN); step(); idle();
      vectors++; if (o_fb_valid !== 1'b0) begin miscompares++; $display("FAIL single_fb_early got %0b exp 0", o_fb_valid); end
      step();
      vectors++; if (o_fb_valid !== 1'b1) begin miscompares++; $display("FAIL single_fb_valid got %0b exp 1", o_fb_valid); end
      vectors++; if (o_fb_pc !== 32'h100) begin miscompares++; $display("FAIL single_fb_pc got %h exp 100", o_fb_pc); end
      vectors++; if (o_fb_ghistory !== 12'h0A5) begin miscompares++; $display("FAIL single_fb_gh got %h exp 0a5", o_fb_ghistory); end
      vectors++; if (o_fb_prediction !== NOT_TAKEN || o_fb_outcome !== NOT_TAKEN) begin miscompares++; $display("FAIL single_fb_dir got %0d/%0d exp 0/0", o_fb_prediction, o_fb_outcome); end
      vectors++; if (o_redirect_valid !== 1'b0) begin miscompares++; $display("FAIL single_redirect got %0b exp 0", o_redirect_valid); end
      vectors++; if (o_branch_count !== 32'd1 || o_mispredict_count !== 32'd0) begin miscompares++; $display("FAIL single_counts got %0d/%0d exp 1/0", o_branch_count, o_mispredict_count); end
      step();
      vectors++; if (o_fb_valid !== 1'b0 || o_fb_pc !== 32'h100) begin miscompares++; $display("FAIL single_fb_pulse got %0b/%h exp 0/100", o_fb_valid, o_fb_pc); end
   endtask

   task automatic test_mispredict();
      do_reset();
      alloc(32'h300, 32'h400, TAKEN, 12'h123); step(); idle();
      resolve(2'd0, NOT_TAKEN); step(); idle();
      // Wrong-path allocation arrives in the mispredicting retire cycle.
      alloc(32'h500, 32'h600, TAKEN, 12'h001); step(); idle();
      vectors++; if (o_redirect_valid !== 1'b1 || o_fb_valid !== 1'b1) begin miscompares++; $display("FAIL mp_pulses got %0b/%0b exp 1/1", o_redirect_valid, o_fb_valid); end
      vectors++; if (o_redirect_pc !== 32'h308) begin miscompares++; $display("FAIL mp_redirect_pc got %h exp 308", o_redirect_pc); end
      vectors++; if (o_fb_outcome !== NOT_TAKEN || o_fb_prediction !== TAKEN) begin miscompares++; $display("FAIL mp_fb_dir got %0d/%0d exp 0/1", o_fb_outcome, o_fb_prediction); end
      vectors++; if (o_mispredict_count !== 32'd1 || o_branch_count !== 32'd1) begin miscompares++; $display("FAIL mp_counts got %0d/%0d exp 1/1", o_mispredict_count, o_branch_count); end
      vectors++; if (o_alloc_tag !== 2'd1 || o_alloc_ready !== 1'b1) begin miscompares++; $display("FAIL mp_wrong_path got tag %0d ready %0b exp 1/1", o_alloc_tag, o_alloc_ready); end
      step();
      vectors++; if (o_redirect_valid !== 1'b0 || o_fb_valid !== 1'b0) begin miscompares++; $display("FAIL mp_pulse_end got %0b/%0b exp 0/0", o_redirect_valid, o_fb_valid); end
      // Opposite direction: predicted not-taken, actually taken -> target.
      alloc(32'h600, 32'h700, NOT_TAKEN, 12'h002); step(); idle();
      resolve(2'd1, TAKEN); step(); idle(); step();
      vectors++; if (o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h700) begin miscompares++; $display("FAIL mp_taken got %0b/%h exp 1/700", o_redirect_valid, o_redirect_pc); end
      vectors++; if (o_mispredict_count !== 32'd2 || o_alloc_tag !== 2'd2) begin miscompares++; $display("FAIL mp_taken_state got cnt %0d tag %0d exp 2/2", o_mispredict_count, o_alloc_tag); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         vectors++; if (o_alloc_tag !== TW'(i)) begin miscompares++; $display("FAIL full_tag%0d got %0d exp %0d", i, o_alloc_tag, i); end
         alloc(32'h1000 + 32'(i * 16), 32'h8000, NOT_TAKEN, 12'(i)); step();
      end
      idle();
      vectors++; if (o_alloc_ready !== 1'b0 || o_alloc_tag !== 2'd0) begin miscompares++; $display("FAIL full_ready got %0b tag %0d exp 0/0", o_alloc_ready, o_alloc_tag); end
      alloc(32'h9000, 32'h9100, TAKEN, 12'hFFF); step(); idle();
      vectors++; if (o_alloc_ready !== 1'b0 || o_alloc_tag !== 2'd0) begin miscompares++; $display("FAIL full_drop got %0b tag %0d exp 0/0", o_alloc_ready, o_alloc_tag); end
      resolve(2'd0, NOT_TAKEN); step(); idle();
      vectors++; if (o_alloc_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_pre got %0b exp 0", o_alloc_ready); end
      // Allocation during the retire cycle is still refused: ready was low.
      alloc(32'h9200, 32'h9300, TAKEN, 12'hEEE); step(); idle();
      vectors++; if (o_alloc_ready !== 1'b1 || o_alloc_tag !== 2'd0) begin miscompares++; $display("FAIL full_ready_post got %0b tag %0d exp 1/0", o_alloc_ready, o_alloc_tag); end
      vectors++; if (o_fb_valid !== 1'b1 || o_fb_pc !== 32'h1000) begin miscompares++; $display("FAIL full_fb got %0b/%h exp 1/1000", o_fb_valid, o_fb_pc); end
   endtask

   task automatic test_out_of_order();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         alloc(32'h2000 + 32'(i * 16), 32'h5000, TAKEN, 12'h100 + 12'(i)); step();
      end
      idle();
      resolve(2'd2, TAKEN); step();
      vectors++; if (o_fb_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_fb_r2 got %0b exp 0", o_fb_valid); end
      resolve(2'd1, TAKEN); step();
      vectors++; if (o_fb_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_fb_r1 got %0b exp 0", o_fb_valid); end
      resolve(2'd0, TAKEN); step(); idle();
      vectors++; if (o_fb_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_fb_r0 got %0b exp 0", o_fb_valid); end
      for (int k = 0; k < 3; k++) begin
         step();
         vectors++; if (o_fb_valid !== 1'b1 || o_fb_pc !== 32'h2000 + 32'(k * 16)) begin miscompares++; $display("FAIL ooo_fb%0d got %0b/%h exp 1/%h", k, o_fb_valid, o_fb_pc, 32'h2000 + 32'(k * 16)); end
         vectors++; if (o_fb_ghistory !== 12'h100 + 12'(k) || o_redirect_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_gh%0d got %h/%0b exp %h/0", k, o_fb_ghistory, o_redirect_valid, 12'h100 + 12'(k)); end
      end
      step();
      vectors++; if (o_fb_valid !== 1'b0 || o_branch_count !== 32'd3) begin miscompares++; $display("FAIL ooo_end got %0b cnt %0d exp 0/3", o_fb_valid, o_branch_count); end
   endtask

   task automatic test_flush();
      do_reset();
      alloc(32'h3000, 32'h3400, TAKEN, 12'h0); step();
      for (int i = 1; i < DEPTH; i++) begin
         alloc(32'h3000 + 32'(i * 16), 32'h3400, NOT_TAKEN, 12'(i)); step();
      end
      idle();
      for (int i = 1; i < DEPTH; i++) begin
         resolve(TW'(i), NOT_TAKEN); step();
         vectors++; if (o_fb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_fb_r%0d got %0b exp 0", i, o_fb_valid); end
      end
      resolve(2'd0, NOT_TAKEN); step(); idle();
      alloc(32'h9400, 32'h9500, TAKEN, 12'hABC); step(); idle();
      vectors++; if (o_fb_valid !== 1'b1 || o_redirect_valid !== 1'b1) begin miscompares++; $display("FAIL flush_pulses got %0b/%0b exp 1/1", o_fb_valid, o_redirect_valid); end
      vectors++; if (o_redirect_pc !== 32'h3008 || o_fb_pc !== 32'h3000) begin miscompares++; $display("FAIL flush_pcs got %h/%h exp 3008/3000", o_redirect_pc, o_fb_pc); end
      vectors++; if (o_alloc_tag !== 2'd1 || o_alloc_ready !== 1'b1) begin miscompares++; $display("FAIL flush_tail got tag %0d ready %0b exp 1/1", o_alloc_tag, o_alloc_ready); end
      for (int k = 0; k < 5; k++) begin
         step();
         vectors++; if (o_fb_valid !== 1'b0 || o_branch_count !== 32'd1) begin miscompares++; $display("FAIL flush_quiet%0d got %0b cnt %0d exp 0/1", k, o_fb_valid, o_branch_count); end
      end
      vectors++; if (o_mispredict_count !== 32'd1 || o_alloc_tag !== 2'd1) begin miscompares++; $display("FAIL flush_final got mp %0d tag %0d exp 1/1", o_mispredict_count, o_alloc_tag); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      alloc(32'h4000, 32'h4400, NOT_TAKEN, 12'h055); step(); idle();
      resolve(2'd0, NOT_TAKEN); step(); idle(); step();
      vectors++; if (o_branch_count !== 32'd1 || o_fb_pc !== 32'h4000) begin miscompares++; $display("FAIL rmid_pre got cnt %0d pc %h exp 1/4000", o_branch_count, o_fb_pc); end
      for (int i = 1; i < DEPTH; i++) begin
         alloc(32'h4000 + 32'(i * 16), 32'h4400, NOT_TAKEN, 12'(i)); step();
      end
      idle();
      #2 rst = 1'b1;
      #1;
      vectors++; if (o_alloc_ready !== 1'b1 || o_alloc_tag !== 2'd0) begin miscompares++; $display("FAIL rmid_alloc got %0b tag %0d exp 1/0", o_alloc_ready, o_alloc_tag); end
      vectors++; if (o_fb_valid !== 1'b0 || o_fb_pc !== 32'h0 || o_fb_ghistory !== 12'h0) begin miscompares++; $display("FAIL rmid_fb got %0b/%h/%h exp 0/0/0", o_fb_valid, o_fb_pc, o_fb_ghistory); end
      vectors++; if (o_branch_count !== 32'd0 || o_mispredict_count !== 32'd0) begin miscompares++; $display("FAIL rmid_counts got %0d/%0d exp 0/0", o_branch_count, o_mispredict_count); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         resolve(TW'(i), NOT_TAKEN); step();
      end
      idle();
      for (int k = 0; k < 4; k++) begin
         step();
         vectors++; if (o_fb_valid !== 1'b0 || o_branch_count !== 32'd0) begin miscompares++; $display("FAIL rmid_quiet%0d got %0b cnt %0d exp 0/0", k, o_fb_valid, o_branch_count); end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      idle();
      test_reset();
      test_correct_retire();
      test_mispredict();
      test_full();
      test_out_of_order();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired before the test sequence completed");
      $fatal(1, "watchdog");
   end

endmodule
